// File: rtl/prbs_level_shaper.sv
// Shapes a PRBS bit stream into DAC codes with optional linear edge ramps.
// Levels and ramp step are captured once per bit and held in shadow registers.
module prbs_level_shaper #(
   parameter int DAC_W = 14
) (
   input  logic             dac_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             bit_strobe,
   input  logic             bit_in,
   input  logic             invert,
   input  logic [DAC_W-1:0] level_high,
   input  logic [DAC_W-1:0] level_low,
   input  logic [DAC_W-1:0] ramp_step,
   output logic [DAC_W-1:0] dac_data,
   output logic             edge_busy,
   output logic             edge_overrun
);

   typedef enum logic [1:0] {IDLE, HOLD, RAMP_UP, RAMP_DN} state_t;

   state_t           state, state_n;
   logic             strobe_d;
   logic             sample;
   logic             overrun_n;
   logic [DAC_W-1:0] target, step_r, low_r;
   logic [DAC_W-1:0] target_n, step_n, low_n, dac_n;
   logic [DAC_W-1:0] new_target;

   // Rising step, clamped at the target using one extra bit so it never wraps.
   function automatic logic [DAC_W-1:0] step_up(input logic [DAC_W-1:0] cur,
                                                input logic [DAC_W-1:0] step,
                                                input logic [DAC_W-1:0] tgt);
      logic [DAC_W:0] sum;
      sum = {1'b0, cur} + {1'b0, step};
      return (sum >= {1'b0, tgt}) ? tgt : sum[DAC_W-1:0];
   endfunction

   // Falling step, clamped at the target; signed difference catches underflow.
   function automatic logic [DAC_W-1:0] step_dn(input logic [DAC_W-1:0] cur,
                                                input logic [DAC_W-1:0] step,
                                                input logic [DAC_W-1:0] tgt);
      logic signed [DAC_W:0] diff;
      diff = $signed({1'b0, cur}) - $signed({1'b0, step});
      return (diff <= $signed({1'b0, tgt})) ? tgt : diff[DAC_W-1:0];
   endfunction

   assign sample     = strobe_d & enable;
   assign new_target = (bit_in ^ invert) ? level_high : level_low;
   assign edge_busy  = (state == RAMP_UP) || (state == RAMP_DN);

   always_comb begin
      state_n   = state;
      dac_n     = dac_data;
      target_n  = target;
      step_n    = step_r;
      low_n     = low_r;
      overrun_n = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         dac_n   = low_r;
      end else if (sample) begin
         target_n  = new_target;
         step_n    = ramp_step;
         low_n     = level_low;
         overrun_n = edge_busy;
         // A new bit always restarts from the current code, never jumps.
         if ((ramp_step == '0) || (new_target == dac_data)) begin
            dac_n   = new_target;
            state_n = HOLD;
         end else if (new_target > dac_data) begin
            dac_n   = step_up(dac_data, ramp_step, new_target);
            state_n = (dac_n == new_target) ? HOLD : RAMP_UP;
         end else begin
            dac_n   = step_dn(dac_data, ramp_step, new_target);
            state_n = (dac_n == new_target) ? HOLD : RAMP_DN;
         end
      end else begin
         case (state)
            IDLE: dac_n = low_r;
            HOLD: dac_n = dac_data;
            RAMP_UP: begin
               dac_n = step_up(dac_data, step_r, target);
               if (dac_n == target) state_n = HOLD;
            end
            RAMP_DN: begin
               dac_n = step_dn(dac_data, step_r, target);
               if (dac_n == target) state_n = HOLD;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge dac_clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         strobe_d     <= 1'b0;
         dac_data     <= '0;
         target       <= '0;
         step_r       <= '0;
         low_r        <= '0;
         edge_overrun <= 1'b0;
      end else begin
         state        <= state_n;
         strobe_d     <= bit_strobe;
         dac_data     <= dac_n;
         target       <= target_n;
         step_r       <= step_n;
         low_r        <= low_n;
         edge_overrun <= overrun_n;
      end
   end

endmodule

// File: tb/tb_prbs_level_shaper.sv
// Scoreboard bench for prbs_level_shaper: expectations are queued per cycle
// as bits are driven and compared on the falling clock edge.
module tb_prbs_level_shaper;

   localparam int DAC_W = 14;

   logic             dac_clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             bit_strobe;
   logic             bit_in;
   logic             invert;
   logic [DAC_W-1:0] level_high;
   logic [DAC_W-1:0] level_low;
   logic [DAC_W-1:0] ramp_step;
   logic [DAC_W-1:0] dac_data;
   logic             edge_busy;
   logic             edge_overrun;

   typedef struct {
      int   cyc;
      int   dac;
      logic busy;
      logic ovr;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   prbs_level_shaper #(.DAC_W(DAC_W)) dut (
      .dac_clk      (dac_clk),
      .reset        (reset),
      .enable       (enable),
      .bit_strobe   (bit_strobe),
      .bit_in       (bit_in),
      .invert       (invert),
      .level_high   (level_high),
      .level_low    (level_low),
      .ramp_step    (ramp_step),
      .dac_data     (dac_data),
      .edge_busy    (edge_busy),
      .edge_overrun (edge_overrun)
   );

   always #5 dac_clk = ~dac_clk;

   always @(posedge dac_clk) cyc <= cyc + 1;

   task automatic chk_val(input string tag, input int obs, input int req);
      checks++;
      if (obs !== req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, req);
      end
   endtask

   task automatic exp_at(input int c, input int dac, input logic busy, input logic ovr);
      exp_t e;
      e.cyc  = c;
      e.dac  = dac;
      e.busy = busy;
      e.ovr  = ovr;
      exp_q.push_back(e);
   endtask

   always @(negedge dac_clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         chk_val($sformatf("dac@%0d", e.cyc), int'(dac_data), e.dac);
         chk_val($sformatf("busy@%0d", e.cyc), int'(edge_busy), int'(e.busy));
         chk_val($sformatf("ovr@%0d", e.cyc), int'(edge_overrun), int'(e.ovr));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge dac_clk);
      #1;
   endtask

   // Pulse bit_strobe for one cycle; t is the cycle the pulse is high.
   task automatic strobe_bit(input logic b, output int t);
      @(posedge dac_clk);
      #1;
      bit_strobe = 1'b1;
      bit_in     = b;
      t          = cyc;
      @(posedge dac_clk);
      #1;
      bit_strobe = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int c;
      reset      = 1'b1;
      enable     = 1'b0;
      bit_strobe = 1'b0;
      bit_in     = 1'b0;
      invert     = 1'b0;
      level_high = 14'd1000;
      level_low  = 14'd0;
      ramp_step  = 14'd0;
      #12;
      chk_val("rst_dac", int'(dac_data), 0);
      chk_val("rst_busy", int'(edge_busy), 0);
      chk_val("rst_ovr", int'(edge_overrun), 0);
      idle(1);
      reset  = 1'b0;
      enable = 1'b1;
      idle(2);

      // Instantaneous edge
      strobe_bit(1'b1, t);
      exp_at(t + 1, 0, 1'b0, 1'b0);
      exp_at(t + 2, 1000, 1'b0, 1'b0);
      exp_at(t + 3, 1000, 1'b0, 1'b0);
      idle(3);

      // Ramp 0 -> 1000 in steps of 300
      strobe_bit(1'b0, t);
      exp_at(t + 2, 0, 1'b0, 1'b0);
      idle(2);
      ramp_step = 14'd300;
      strobe_bit(1'b1, t);
      exp_at(t + 2, 300, 1'b1, 1'b0);
      exp_at(t + 3, 600, 1'b1, 1'b0);
      exp_at(t + 4, 900, 1'b1, 1'b0);
      exp_at(t + 5, 1000, 1'b0, 1'b0);
      idle(4);

      // Inputs wiggled without a strobe leave the output alone
      level_high = 14'd500;
      ramp_step  = 14'd7;
      bit_in     = 1'b0;
      invert     = 1'b1;
      for (int i = 1; i <= 4; i++) exp_at(t + 5 + i, 1000, 1'b0, 1'b0);
      idle(5);
      invert = 1'b0;

      // Top-of-range clamp and bottom clamp
      level_high = 14'd16383;
      level_low  = 14'd16000;
      ramp_step  = 14'd0;
      strobe_bit(1'b0, t);
      exp_at(t + 2, 16000, 1'b0, 1'b0);
      idle(2);
      ramp_step = 14'd1000;
      strobe_bit(1'b1, t);
      exp_at(t + 2, 16383, 1'b0, 1'b0);
      exp_at(t + 3, 16383, 1'b0, 1'b0);
      idle(2);
      strobe_bit(1'b0, t);
      exp_at(t + 2, 16000, 1'b0, 1'b0);
      exp_at(t + 3, 16000, 1'b0, 1'b0);
      idle(2);
      level_low = 14'd100;
      ramp_step = 14'd16383;
      strobe_bit(1'b0, t);
      exp_at(t + 2, 100, 1'b0, 1'b0);
      exp_at(t + 3, 100, 1'b0, 1'b0);
      idle(2);

      // Overrun: new bit while ramping up at 400
      level_high = 14'd1000;
      level_low  = 14'd0;
      ramp_step  = 14'd0;
      strobe_bit(1'b0, t);
      exp_at(t + 2, 0, 1'b0, 1'b0);
      idle(2);
      ramp_step = 14'd100;
      strobe_bit(1'b1, t);
      exp_at(t + 2, 100, 1'b1, 1'b0);
      exp_at(t + 3, 200, 1'b1, 1'b0);
      exp_at(t + 4, 300, 1'b1, 1'b0);
      exp_at(t + 5, 400, 1'b1, 1'b0);
      idle(2);
      strobe_bit(1'b0, t);
      exp_at(t + 2, 300, 1'b1, 1'b1);
      exp_at(t + 3, 200, 1'b1, 1'b0);
      exp_at(t + 4, 100, 1'b1, 1'b0);
      exp_at(t + 5, 0, 1'b0, 1'b0);
      exp_at(t + 6, 0, 1'b0, 1'b0);
      idle(6);

      // Inverted bit selects low level (above high); enable drop aborts ramp
      level_high = 14'd100;
      level_low  = 14'd800;
      invert     = 1'b1;
      ramp_step  = 14'd100;
      strobe_bit(1'b1, t);
      exp_at(t + 2, 100, 1'b1, 1'b0);
      exp_at(t + 3, 200, 1'b1, 1'b0);
      for (int i = 4; i <= 9; i++) exp_at(t + i, 800, 1'b0, 1'b0);
      idle(2);
      enable = 1'b0;
      strobe_bit(1'b0, t);
      idle(5);
      enable = 1'b1;
      invert = 1'b0;
      c = cyc;
      exp_at(c + 1, 800, 1'b0, 1'b0);
      idle(2);

      // Asynchronous reset in the middle of a ramp
      level_high = 14'd1000;
      level_low  = 14'd0;
      ramp_step  = 14'd0;
      strobe_bit(1'b0, t);
      exp_at(t + 2, 0, 1'b0, 1'b0);
      idle(2);
      ramp_step = 14'd100;
      strobe_bit(1'b1, t);
      exp_at(t + 2, 100, 1'b1, 1'b0);
      idle(2);
      #2;
      reset = 1'b1;
      #1;
      chk_val("mid_rst_dac", int'(dac_data), 0);
      chk_val("mid_rst_busy", int'(edge_busy), 0);
      chk_val("mid_rst_ovr", int'(edge_overrun), 0);
      idle(1);
      reset = 1'b0;
      c = cyc;
      for (int i = 0; i <= 5; i++) exp_at(c + i, 0, 1'b0, 1'b0);

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
      chk_val("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
